// File: rtl/lzd_pipe.sv
// Three-stage leading-zero/leading-one detector with left normaliser and a valid/ready elastic pipeline.
// S1 registers the operand, S2 the LZD tree result, and S3 the shifted result, which drives the outputs.
module lzd_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_src,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_cnt,
  output logic             out_v,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  // Returns {found, count}. Nodes are reduced in place, MSB half first; count is forced to 0 when nothing is found.
  function automatic logic [CW:0] lzd_tree(input logic [WIDTH-1:0] x);
    logic [CW-1:0] c [WIDTH/2];
    logic          v [WIDTH/2];
    for (int i = 0; i < WIDTH/2; i++) begin
      v[i] = x[WIDTH-1-2*i] | x[WIDTH-2-2*i];
      c[i] = {{(CW-1){1'b0}}, ~x[WIDTH-1-2*i]};
    end
    for (int l = 1; l < CW; l++) begin
      for (int i = 0; i < (WIDTH >> (l+1)); i++) begin
        c[i] = v[2*i] ? c[2*i] : ((CW'(1) << l) | c[2*i+1]);
        v[i] = v[2*i] | v[2*i+1];
      end
    end
    return {v[0], (v[0] ? c[0] : {CW{1'b0}})};
  endfunction

  function automatic logic [WIDTH-1:0] norm_shift(input logic [WIDTH-1:0] x, input logic [CW-1:0] n);
    return x << n;
  endfunction

  logic             r_vld_p1, r_vld_p2, r_vld_p3;
  logic [WIDTH-1:0] r_src_p1, r_src_p2, r_norm_p3;
  logic             r_inv_p1;
  logic [TAG_W-1:0] r_tag_p1, r_tag_p2, r_tag_p3;
  logic [CW-1:0]    r_cnt_p2, r_cnt_p3;
  logic             r_v_p2, r_v_p3;

  logic             w_ld1, w_ld2, w_ld3;
  logic [CW:0]      w_lzd;

  assign w_ld3    = ~r_vld_p3 | out_ready;
  assign w_ld2    = ~r_vld_p2 | w_ld3;
  assign w_ld1    = ~r_vld_p1 | w_ld2;
  assign in_ready = w_ld1;
  assign w_lzd    = lzd_tree(r_src_p1 ^ {WIDTH{r_inv_p1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
      r_src_p1  <= '0;
      r_inv_p1  <= 1'b0;
      r_tag_p1  <= '0;
      r_src_p2  <= '0;
      r_tag_p2  <= '0;
      r_cnt_p2  <= '0;
      r_v_p2    <= 1'b0;
      r_norm_p3 <= '0;
      r_tag_p3  <= '0;
      r_cnt_p3  <= '0;
      r_v_p3    <= 1'b0;
    end else begin
      // S1: operand capture
      if (w_ld1) begin
        r_vld_p1 <= in_valid;
        if (in_valid) begin
          r_src_p1 <= in_src;
          r_inv_p1 <= in_inv;
          r_tag_p1 <= in_tag;
        end
      end
      // S2: leading-bit count
      if (w_ld2) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_src_p2 <= r_src_p1;
          r_tag_p2 <= r_tag_p1;
          r_cnt_p2 <= w_lzd[CW-1:0];
          r_v_p2   <= w_lzd[CW];
        end
      end
      // S3: normalised result
      if (w_ld3) begin
        r_vld_p3 <= r_vld_p2;
        if (r_vld_p2) begin
          r_norm_p3 <= norm_shift(r_src_p2, r_cnt_p2);
          r_tag_p3  <= r_tag_p2;
          r_cnt_p3  <= r_cnt_p2;
          r_v_p3    <= r_v_p2;
        end
      end
    end
  end

  assign out_valid = r_vld_p3;
  assign out_cnt   = r_cnt_p3;
  assign out_v     = r_v_p3;
  assign out_norm  = r_norm_p3;
  assign out_tag   = r_tag_p3;

endmodule

// File: tb/tb_lzd_pipe.sv
// Bench for lzd_pipe: directed 16-bit vectors, backpressure and mid-flight reset, plus random streams on 64- and 4-bit instances.
module tb_lzd_pipe;

  typedef struct packed {
    logic [63:0] norm;
    logic [6:0]  cnt;
    logic        v;
    logic [3:0]  tag;
  } res_t;

  typedef struct {
    logic [15:0] src;
    logic        inv;
    logic [3:0]  tag;
    logic [3:0]  cnt;
    logic        v;
    logic [15:0] norm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_inv, out_valid, out_ready, out_v;
  logic [15:0] in_src, out_norm;
  logic [3:0]  in_tag, out_tag, out_cnt;

  logic        rin_valid, rout_ready, rinv64, rinv4;
  logic [63:0] rsrc64, rnorm64;
  logic [3:0]  rsrc4, rtag, rnorm4, rtag64, rtag4;
  logic        rrdy64, rvld64, rv64, rrdy4, rvld4, rv4;
  logic [5:0]  rcnt64;
  logic [1:0]  rcnt4;

  lzd_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_cnt(out_cnt), .out_v(out_v), .out_norm(out_norm), .out_tag(out_tag));

  lzd_pipe #(.WIDTH(64), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(rin_valid), .in_ready(rrdy64), .in_src(rsrc64),
    .in_inv(rinv64), .in_tag(rtag), .out_valid(rvld64), .out_ready(rout_ready),
    .out_cnt(rcnt64), .out_v(rv64), .out_norm(rnorm64), .out_tag(rtag64));

  lzd_pipe #(.WIDTH(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(rin_valid), .in_ready(rrdy4), .in_src(rsrc4),
    .in_inv(rinv4), .in_tag(rtag), .out_valid(rvld4), .out_ready(rout_ready),
    .out_cnt(rcnt4), .out_v(rv4), .out_norm(rnorm4), .out_tag(rtag4));

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp16[$];
  res_t exp64[$];
  res_t exp4[$];
  res_t pend, held;
  bit   held_v = 1'b0;
  int   max_fl = 0;
  vec_t tbl[12];

  function automatic res_t mkres(input logic [63:0] n, input logic [6:0] c, input logic v, input logic [3:0] t);
    res_t r;
    r.norm = n; r.cnt = c; r.v = v; r.tag = t;
    return r;
  endfunction

  function automatic res_t act16();
    return mkres(64'(out_norm), 7'(out_cnt), out_v, out_tag);
  endfunction

  function automatic res_t exp_of(input vec_t e);
    return mkres(64'(e.norm), 7'(e.cnt), e.v, e.tag);
  endfunction

  // Reference: scan from the MSB for the first bit that differs from inv.
  function automatic res_t ref_lz(input logic [63:0] x, input int w, input logic inv, input logic [3:0] tag);
    res_t        r;
    logic [63:0] m;
    bit          found;
    found = 1'b0;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r = mkres(x, 7'd0, 1'b0, tag);
    for (int i = w - 1; i >= 0; i--) begin
      if (!found && (x[i] != inv)) begin
        found = 1'b1;
        r.cnt = 7'(w - 1 - i);
      end
    end
    r.v = found;
    if (found) r.norm = (x << r.cnt) & m;
    return r;
  endfunction

  task automatic chk1(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic cmp_res(input string nm, input res_t act, input res_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d v=%0b norm=%h tag=%0d, required cnt=%0d v=%0b norm=%h tag=%0d",
               nm, act.cnt, act.v, act.norm, act.tag, req.cnt, req.v, req.norm, req.tag);
    end
  endtask

  task automatic unexpected(input string nm, input logic [3:0] t);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got output with tag=%0d, required no output", nm, t);
  endtask

  // Called at posedge+1 with inputs driven; samples on the negedge and returns whether the input was accepted.
  task automatic tick16(output bit acc);
    @(negedge clk);
    if (held_v && out_valid) cmp_res("stall_stable", act16(), held);
    held_v = out_valid && !out_ready;
    held   = act16();
    if (out_valid && out_ready) begin
      if (exp16.size() == 0) unexpected("out16_extra", out_tag);
      else cmp_res("out16", act16(), exp16.pop_front());
    end
    acc = in_valid && in_ready;
    if (acc) exp16.push_back(pend);
    if (exp16.size() > max_fl) max_fl = exp16.size();
    @(posedge clk); #1;
  endtask

  task automatic tickr();
    @(negedge clk);
    if (rvld64 && rout_ready) begin
      if (exp64.size() == 0) unexpected("out64_extra", rtag64);
      else cmp_res("out64", mkres(rnorm64, 7'(rcnt64), rv64, rtag64), exp64.pop_front());
    end
    if (rvld4 && rout_ready) begin
      if (exp4.size() == 0) unexpected("out4_extra", rtag4);
      else cmp_res("out4", mkres(64'(rnorm4), 7'(rcnt4), rv4, rtag4), exp4.pop_front());
    end
    if (rin_valid && rrdy64) exp64.push_back(ref_lz(rsrc64, 64, rinv64, rtag));
    if (rin_valid && rrdy4)  exp4.push_back(ref_lz(64'(rsrc4), 4, rinv4, rtag));
    @(posedge clk); #1;
  endtask

  task automatic drive_vec(input vec_t e);
    in_src = e.src; in_inv = e.inv; in_tag = e.tag; pend = exp_of(e);
  endtask

  task automatic drain16(input string nm);
    bit a;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 12 && exp16.size() > 0; j++) tick16(a);
    chk1(nm, 64'(exp16.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   a, fnd, any_v;
    int   k, idx;

    //            src      inv   tag   cnt   v     norm
    tbl[0]  = '{16'h0100, 1'b0, 4'd3,  4'd7,  1'b1, 16'h8000};
    tbl[1]  = '{16'h8000, 1'b0, 4'd1,  4'd0,  1'b1, 16'h8000};
    tbl[2]  = '{16'h0001, 1'b0, 4'd2,  4'd15, 1'b1, 16'h8000};
    tbl[3]  = '{16'h0000, 1'b0, 4'd4,  4'd0,  1'b0, 16'h0000};
    tbl[4]  = '{16'hFFFF, 1'b1, 4'd5,  4'd0,  1'b0, 16'hFFFF};
    tbl[5]  = '{16'hF0FF, 1'b1, 4'd6,  4'd4,  1'b1, 16'h0FF0};
    tbl[6]  = '{16'h7FFF, 1'b1, 4'd7,  4'd0,  1'b1, 16'h7FFF};
    tbl[7]  = '{16'h0FFF, 1'b0, 4'd8,  4'd4,  1'b1, 16'hFFF0};
    tbl[8]  = '{16'h0035, 1'b0, 4'd9,  4'd10, 1'b1, 16'hD400};
    tbl[9]  = '{16'hFFFE, 1'b1, 4'd10, 4'd15, 1'b1, 16'h0000};
    tbl[10] = '{16'hC3A5, 1'b1, 4'd11, 4'd2,  1'b1, 16'h0E94};
    tbl[11] = '{16'hFFFF, 1'b0, 4'd12, 4'd0,  1'b1, 16'hFFFF};

    rst_n = 1'b0;
    in_valid = 1'b0; in_src = '0; in_inv = 1'b0; in_tag = '0; out_ready = 1'b1;
    rin_valid = 1'b0; rout_ready = 1'b1; rsrc64 = '0; rsrc4 = '0; rinv64 = 1'b0; rinv4 = 1'b0; rtag = '0;
    #12;
    chk1("reset_outs", 64'({out_valid, out_cnt, out_v, out_norm, out_tag}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("reset_in_ready", 64'(in_ready), 64'd1);

    // Single operand latency: accepted at edge N, visible after edge N+2.
    drive_vec(tbl[0]); in_valid = 1'b1;
    @(negedge clk);
    chk1("lat_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    fnd = 1'b0; k = 0;
    for (int j = 1; j <= 6 && !fnd; j++) begin
      @(negedge clk);
      if (out_valid) begin fnd = 1'b1; k = j; end
    end
    chk1("latency", 64'(k), 64'd3);
    if (fnd) cmp_res("lat_result", act16(), exp_of(tbl[0]));
    @(posedge clk); #1;

    // Directed table, back-to-back.
    for (int i = 0; i < 12; i++) begin
      drive_vec(tbl[i]); in_valid = 1'b1;
      a = 1'b0;
      for (int j = 0; j < 5 && !a; j++) tick16(a);
      chk1("tbl_accept", 64'(a), 64'd1);
    end
    drain16("tbl_drain");

    // Backpressure: out_ready low for cycles 4..8, operands tagged 0..9.
    max_fl = 0; idx = 0;
    for (int c = 0; c < 40 && (idx < 10 || exp16.size() > 0); c++) begin
      in_valid = (idx < 10);
      in_src = 16'h8000 >> idx; in_inv = 1'b0; in_tag = 4'(idx);
      pend = mkres(64'h8000, 7'(idx), 1'b1, 4'(idx));
      out_ready = !(c >= 4 && c <= 8);
      #1;
      if (c == 4) chk1("bp_in_ready_low", 64'(in_ready), 64'd0);
      if (c == 9) chk1("bp_in_ready_resume", 64'(in_ready), 64'd1);
      tick16(a);
      if (a) idx++;
    end
    chk1("bp_all_done", 64'({idx[7:0], 8'(exp16.size())}), 64'({8'd10, 8'd0}));
    chk1("bp_occupancy", 64'(max_fl), 64'd3);
    out_ready = 1'b1; in_valid = 1'b0;

    // Reset with three operands in flight.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive_vec(tbl[7 + j]); in_valid = 1'b1;
      tick16(a);
    end
    chk1("rst_fill", 64'(exp16.size()), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_mid_outs", 64'({out_valid, out_cnt, out_v, out_norm, out_tag}), 64'd0);
    exp16.delete(); held_v = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    any_v = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) chk1("rst_in_ready", 64'(in_ready), 64'd1);
      any_v = any_v | out_valid;
    end
    chk1("rst_no_stale", 64'(any_v), 64'd0);
    @(posedge clk); #1;
    drive_vec(tbl[5]); in_valid = 1'b1;
    tick16(a);
    drain16("rst_recover");

    // Random streams on WIDTH=64 and WIDTH=4.
    for (int c = 0; c < 400; c++) begin
      rin_valid  = 1'($urandom_range(0, 1));
      rout_ready = 1'($urandom_range(0, 1));
      rinv64 = 1'($urandom_range(0, 1));
      rinv4  = 1'($urandom_range(0, 1));
      rsrc64 = {$urandom(), $urandom()} >> $urandom_range(0, 64);
      if (rinv64) rsrc64 = ~rsrc64;
      rsrc4 = 4'($urandom_range(0, 15));
      rtag  = 4'(c);
      tickr();
    end
    rin_valid = 1'b0; rout_ready = 1'b1;
    for (int j = 0; j < 10; j++) tickr();
    chk1("rand_drain", 64'({16'(exp64.size()), 16'(exp4.size())}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzd_pipe.md
# lzd_pipe

Parametrised, pipelined leading-zero/leading-one detector with normaliser. It accepts one WIDTH-bit operand per cycle over a valid/ready handshake. It returns the leading-bit count, a found flag and the operand left-normalised by that count. It sits in front of floating-point normalisation and rounding paths, where the combinational 2-/4-bit LZD trees are too slow for wide operands.

## Interface
- WIDTH, 16: operand width; power of two, 4..64.
- TAG_W, 4: sideband tag width, carried unchanged alongside each operand; minimum 1.
- CW (local), $clog2(WIDTH): count width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept an operand this cycle.
- in_src  in  WIDTH  operand.
- in_inv  in  1  0: count leading zeros; 1: count leading ones.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts the result this cycle.
- out_cnt  out  CW  number of leading bits equal to ~target before the first target bit.
- out_v  out  1  a target bit was found (1 when the operand is in_inv ? not all ones : not all zeros).
- out_norm  out  WIDTH  in_src << out_cnt, zero-filled.
- out_tag  out  TAG_W  tag of this result.

## Operation
- Target bit is 1 when in_inv=0 and 0 when in_inv=1. The tree operates on in_src ^ {WIDTH{in_inv}}.
- The pipeline has three register stages, each with its own valid bit:
  - S1 captures in_src, in_inv and in_tag.
  - S2 holds the LZD result (cnt, v) plus the original src and tag. The LZD is a log2(WIDTH)-level 2:1 combine tree, lzd_2bits leaves and lzdu-style merges.
  - S3 holds the shifted result and drives the out_* ports directly.
- Found flag out_v=0: out_cnt=0 and out_norm=in_src unshifted.
- Found flag out_v=1: out_cnt ranges 0..WIDTH-1. The MSB of out_norm equals the target bit.
- Elastic stall rule, per stage k: stage k loads when (~valid_k | advance_{k+1}). For S3, advance = out_ready.
  - in_ready = ~valid_S1 | advance_S2 (combinational chain, no bubble).
  - A stage that does not load holds data and valid unchanged.
- A stage with valid_k=0 loads regardless. An empty stage never blocks upstream.
- Transactions complete in order, with no drop and no duplication. Tag stays with its operand.
- in_src is ignored when in_valid=0. out_* contents are don't-care when out_valid=0, but must be stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n=0, asynchronous):
  - All valid bits clear; out_valid=0.
  - out_cnt=0, out_v=0, out_norm=0, out_tag=0, all data registers 0.
  - in_ready=1 from the first cycle after rst_n deasserts.
- Latency: an operand accepted at edge N (in_valid & in_ready) is presented on out_* after edge N+2. That is 3 register stages, with out_valid high in the cycle following edge N+2.
- Throughput: 1 operand/cycle while out_ready=1. Sustained back-to-back transfers have no idle cycles.
- Backpressure:
  - With out_ready held low, the pipeline absorbs exactly 3 operands.
  - in_ready falls combinationally in the cycle S1 is full and cannot advance.
  - When out_ready rises, the output transfers at that edge and in_ready is high in the same cycle.
- Simultaneous output transfer and input accept in a full pipeline: all stages shift together, and occupancy stays 3.
- Reset mid-operation: all in-flight results are discarded. No out_valid pulse may appear during or after reset until a new operand is accepted.

## Test plan
- WIDTH=16, out_ready=1, no inversion:
  - in_src=0x0100, in_inv=0, tag=3 → 3 cycles later out_cnt=7, out_v=1, out_norm=0x8000, out_tag=3.
  - Then 0x8000 → cnt=0, norm=0x8000.
  - Then 0x0001 → cnt=15, norm=0x8000.
- Zero/all-ones operands:
  - in_src=0x0000, inv=0 → out_v=0, cnt=0, norm=0x0000.
  - in_src=0xFFFF, inv=1 → out_v=0, cnt=0, norm=0xFFFF.
- Leading-one mode: in_src=0xF0FF, inv=1 → cnt=4, v=1, norm=0x0FF0.
  - in_src=0x7FFF, inv=1 → cnt=0, norm=0x7FFF.
- Backpressure:
  - Stream 10 operands with tags 0..9, out_ready low for cycles 4-8 → in_ready low after 3 held, no loss.
  - Outputs emerge in tag order 0..9 with correct counts.
  - out_* stable while stalled.
- Random stream, WIDTH=64 and WIDTH=4: random in_valid/out_ready at 50% → every result matches a reference count/shift model, and order is preserved.
- Reset: assert rst_n=0 for 1 cycle with 3 operands in flight → out_valid=0 immediately, all outputs 0, in_ready=1 after release, no stale result emitted.
